serial_alu_seq: RTL
===================

# serial_alu_seq

Bit-serial ALU sequencer: accepts a WIDTH-bit operation request, feeds operand bits LSB-first through a single 1-bit ALU slice (ADD/AND/NOR/XOR), and feeds the carry back between cycles. It assembles the WIDTH-bit result and reports it with a one-cycle done pulse. It sits between a requesting controller and the 1-bit ALU cell, trading WIDTH cycles of latency for a single slice of datapath.

## Interface
- WIDTH, 8, operand/result width in bits (legal: WIDTH >= 2)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  opcode: 00 ADD, 01 AND, 10 NOR, 11 XOR
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used only for ADD
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when result/cout/ovf are valid
- result  out  WIDTH  registered result; held until the next completion
- cout  out  1  carry-out for ADD; 0 for other ops
- ovf  out  1  signed overflow for ADD (see Configuration); 0 for other ops

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch a, b and op into shift registers
  - carry register <= (op==ADD) ? cin : 0
  - bit counter <= 0
  - go to RUN
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - slice input is a_sh[0], b_sh[0], carry
  - slice sum bit shifts into the MSB of the result shift register; shift right
  - a_sh and b_sh shift right
  - carry register <= slice carry (forced 0 for non-ADD)
  - counter increments
- RUN, counter==WIDTH-1: process the final bit, then go to DONE. On the same edge, load result/cout/ovf output registers.
- DONE: done=1 for one cycle, then return to IDLE unconditionally.
- start in RUN or DONE is ignored (no queueing). Inputs a/b/op/cin are don't-care outside the IDLE accept edge.
- Slice functions:
  - ADD: d = a^b^c, e = majority(a,b,c)
  - AND: d = a&b
  - NOR: d = ~(a|b)
  - XOR: d = a^b
  - e = 0 for all non-ADD ops
- Arithmetic is modulo 2^WIDTH. The carry out of bit WIDTH-1 is cout.
- Reset (any time, including mid-RUN):
  - state <= IDLE
  - busy, done, result, cout and ovf <= 0
  - the in-flight operation is discarded and no done is produced

## Timing
- Start accepted at edge k (state IDLE, start=1).
- busy is high from edge k to edge k+WIDTH (exactly WIDTH cycles).
- result, cout and ovf update at edge k+WIDTH.
- done is high from edge k+WIDTH to k+WIDTH+1.
- Minimum spacing between accepted starts: WIDTH+2 cycles. The next start is accepted at edge k+WIDTH+2 at the earliest (IDLE reached at edge k+WIDTH+1).
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro SERIAL_ALU_OVF_EN:
  - Defined: the sequencer records the carry into bit WIDTH-1. For ADD, ovf = carry_into_msb ^ cout, registered with result.
  - Undefined: the ovf port is still present and tied to 0, and the extra carry register is not built.

## Structure
- Shared package serial_alu_pkg holds:
  - opcode constants OP_ADD, OP_AND, OP_NOR, OP_XOR (2-bit)
  - FSM state encodings S_IDLE, S_RUN, S_DONE
- One sub-module, alu_bit_slice: combinational 1-bit cell (inputs a, b, c, op; outputs d, e). It is instantiated once and all sequencing stays in serial_alu_seq.
- Counter width is $clog2(WIDTH).

## Test plan
All scenarios use WIDTH=8.
- ADD a=0x5A, b=0x3C, cin=0 -> result 0x96, cout 0, ovf 1 (macro on); done exactly 8 edges after accept, busy high 8 cycles.
- ADD 0xFF+0x01 cin=0 -> result 0x00, cout 1, ovf 0. ADD 0x7F+0x00 cin=1 -> result 0x80, cout 0, ovf 1.
- Logic ops, each with cin=1 -> cout 0, ovf 0:
  - AND 0xF0,0x3C -> 0x30
  - NOR 0xF0,0x0F -> 0x00
  - XOR 0xAA,0x55 -> 0xFF
- ADD 0x10+0x20 accepted; start re-pulsed with XOR 0xFF,0xFF during RUN and during DONE -> both ignored; result 0x30 with a single done pulse.
- rst asserted mid-RUN after 4 bits -> busy, done, result, cout and ovf are 0 immediately; no done follows. A subsequent ADD 0x01+0x01 -> 0x02 with correct timing.
- Macro undefined: ADD 0x7F+0x01 -> result 0x80, cout 0, ovf stays 0.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared opcode and FSM state encodings for the bit-serial ALU sequencer.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU cell: ADD/AND/NOR/XOR; carry-out e is 0 for logic ops.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [1:0] op,
  output logic       d,
  output logic       e
);

  always_comb begin
    d = 1'b0;
    e = 1'b0;
    case (op)
      OP_ADD: begin
        d = a ^ b ^ c;
        e = (a & b) | (a & c) | (b & c);
      end
      OP_AND:  d = a & b;
      OP_NOR:  d = ~(a | b);
      OP_XOR:  d = a ^ b;
      default: d = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: WIDTH-cycle LSB-first operation through one alu_bit_slice.
// Define SERIAL_ALU_OVF_EN to produce signed overflow for ADD; otherwise ovf is tied 0.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [1:0]       op_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             e;

  alu_bit_slice u_slice (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry),
    .op (op_r),
    .d  (d),
    .e  (e)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_r   <= OP_ADD;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_r  <= op;
            carry <= (op == OP_ADD) ? cin : 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d, res_sh[WIDTH-1:1]};
          carry  <= e;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            result <= {d, res_sh[WIDTH-1:1]};
            cout   <= e;
            // On the final bit the carry register holds the carry into the MSB.
`ifdef SERIAL_ALU_OVF_EN
            ovf    <= carry ^ e;
`else
            ovf    <= 1'b0;
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
